// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, T-state
// encoding and the instruction classes the sequencer dispatches on.
package cpu_defs;

    // 5-bit opcodes taken from IR[31:27]
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Sequencer state; the numeric values are part of the interface
    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_HALTED = 4'd8
    } tstate_t;

    // Instruction classes: each class shares one execute-step strobe pattern
    typedef enum logic [2:0] {
        C_RR,
        C_IMM,
        C_UN,
        C_MD,
        C_NOP,
        C_HALT
    } op_class_t;

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode-to-class decoder. Unlisted opcodes behave as nop.
module op_class_decode
    import cpu_defs::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] opcode,
    output op_class_t      op_class
);

    // Map every opcode onto the execute pattern it uses
    always_comb begin
        op_class = C_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:  op_class = C_RR;
            OP_ADDI, OP_ANDI, OP_ORI:         op_class = C_IMM;
            OP_NEG, OP_NOT:                   op_class = C_UN;
            OP_MUL, OP_DIV:                   op_class = C_MD;
            OP_HALT:                          op_class = C_HALT;
            OP_NOP:                           op_class = C_NOP;
            default:                          op_class = C_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: steps through fetch (T0..T2) and the
// class-specific execute steps, driving the datapath strobes as a pure
// function of the current T-state and the opcode held in IR.
module control_sequencer
    import cpu_defs::*;
#(
    parameter int OPW = 5,
    parameter int IRW = 32
) (
    input  logic           Clock,
    input  logic           Clear,
    input  logic [IRW-1:0] IR,
    input  logic           Stop,
    output logic           Run,
    output logic           PCout,
    output logic           Zhighout,
    output logic           Zlowout,
    output logic           MDRout,
    output logic           HIout,
    output logic           LOout,
    output logic           PCin,
    output logic           MARin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           Zin,
    output logic           HIin,
    output logic           LOin,
    output logic           IncPC,
    output logic           Read,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic           Cout,
    output logic [OPW-1:0] alu_op
);

    tstate_t        state;
    tstate_t        next_state;
    op_class_t      op_class;
    logic [OPW-1:0] opcode;
    logic           ir_unused;
    tstate_t        after_last;

    assign opcode = IR[IRW-1 -: OPW];

    // Only the opcode field steers control; register fields go to the datapath
    assign ir_unused = ^IR[IRW-OPW-1:0];

    op_class_decode #(
        .OPW (OPW)
    ) u_decode (
        .opcode   (opcode),
        .op_class (op_class)
    );

    // Where to go after an instruction's final execute step
    assign after_last = Stop ? ST_HALTED : ST_T0;

    // State register; Clear overrides every transition including halt/Stop
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state <= ST_RST;
        end else begin
            state <= next_state;
        end
    end

    // Next-state sequencing per instruction class
    always_comb begin
        next_state = ST_RST;
        case (state)
            ST_RST: next_state = ST_T0;
            ST_T0:  next_state = ST_T1;
            ST_T1:  next_state = ST_T2;
            ST_T2:  next_state = ST_T3;
            ST_T3: begin
                case (op_class)
                    C_HALT:  next_state = ST_HALTED;
                    C_NOP:   next_state = after_last;
                    default: next_state = ST_T4;
                endcase
            end
            ST_T4: begin
                case (op_class)
                    C_UN:              next_state = after_last;
                    C_RR, C_IMM, C_MD: next_state = ST_T5;
                    default:           next_state = ST_T0;
                endcase
            end
            ST_T5: begin
                if (op_class == C_MD) begin
                    next_state = ST_T6;
                end else begin
                    next_state = after_last;
                end
            end
            ST_T6:     next_state = after_last;
            ST_HALTED: next_state = ST_HALTED;
            default:   next_state = ST_RST;
        endcase
    end

    // Strobe table: Moore outputs from state, with the class picking execute steps
    always_comb begin
        Run      = 1'b0;
        PCout    = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        PCin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        Cout     = 1'b0;
        alu_op   = '0;
        case (state)
            ST_T0: begin
                Run   = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            ST_T1: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                Run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                Run = 1'b1;
                case (op_class)
                    C_RR, C_IMM: begin
                        Grb  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end
                    C_UN: begin
                        Grb    = 1'b1;
                        Rout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = opcode;
                    end
                    C_MD: begin
                        Gra  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                Run = 1'b1;
                case (op_class)
                    C_RR: begin
                        Grc    = 1'b1;
                        Rout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = opcode;
                    end
                    C_IMM: begin
                        Cout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = opcode;
                    end
                    C_UN: begin
                        Zlowout = 1'b1;
                        Gra     = 1'b1;
                        Rin     = 1'b1;
                    end
                    C_MD: begin
                        Grb    = 1'b1;
                        Rout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = opcode;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                Run = 1'b1;
                case (op_class)
                    C_RR, C_IMM: begin
                        Zlowout = 1'b1;
                        Gra     = 1'b1;
                        Rin     = 1'b1;
                    end
                    C_MD: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                Run = 1'b1;
                if (op_class == C_MD) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class
// T-step by T-step and compares every strobe against hand-derived values.
module tb_control_sequencer;

    logic        Clock;
    logic        Clear;
    logic [31:0] IR;
    logic        Stop;
    logic        Run;
    logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
    logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic        IncPC, Read, Gra, Grb, Grc, Rin, Rout, Cout;
    logic [4:0]  alu_op;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    // One-hot masks of the strobe vector below
    localparam logic [21:0] PCOUT    = 22'h200000;
    localparam logic [21:0] ZHIGHOUT = 22'h100000;
    localparam logic [21:0] ZLOWOUT  = 22'h080000;
    localparam logic [21:0] MDROUT   = 22'h040000;
    localparam logic [21:0] PCIN     = 22'h008000;
    localparam logic [21:0] MARIN    = 22'h004000;
    localparam logic [21:0] MDRIN    = 22'h002000;
    localparam logic [21:0] IRIN     = 22'h001000;
    localparam logic [21:0] YIN      = 22'h000800;
    localparam logic [21:0] ZIN      = 22'h000400;
    localparam logic [21:0] HIIN     = 22'h000200;
    localparam logic [21:0] LOIN     = 22'h000100;
    localparam logic [21:0] INCPC    = 22'h000080;
    localparam logic [21:0] READ     = 22'h000040;
    localparam logic [21:0] GRA      = 22'h000020;
    localparam logic [21:0] GRB      = 22'h000010;
    localparam logic [21:0] GRC      = 22'h000008;
    localparam logic [21:0] RIN      = 22'h000004;
    localparam logic [21:0] ROUT     = 22'h000002;
    localparam logic [21:0] COUT     = 22'h000001;

    localparam logic [21:0] F0 = PCOUT | MARIN | INCPC | ZIN;
    localparam logic [21:0] F1 = ZLOWOUT | PCIN | READ | MDRIN;
    localparam logic [21:0] F2 = MDROUT | IRIN;

    logic [21:0] strobes;
    logic [7:0]  bus;

    assign strobes = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
                      PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
                      IncPC, Read, Gra, Grb, Grc, Rin, Rout, Cout};
    assign bus = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Rout, Cout};

    control_sequencer #(.OPW(5), .IRW(32)) dut (
        .Clock    (Clock),
        .Clear    (Clear),
        .IR       (IR),
        .Stop     (Stop),
        .Run      (Run),
        .PCout    (PCout),
        .Zhighout (Zhighout),
        .Zlowout  (Zlowout),
        .MDRout   (MDRout),
        .HIout    (HIout),
        .LOout    (LOout),
        .PCin     (PCin),
        .MARin    (MARin),
        .MDRin    (MDRin),
        .IRin     (IRin),
        .Yin      (Yin),
        .Zin      (Zin),
        .HIin     (HIin),
        .LOin     (LOin),
        .IncPC    (IncPC),
        .Read     (Read),
        .Gra      (Gra),
        .Grb      (Grb),
        .Grc      (Grc),
        .Rin      (Rin),
        .Rout     (Rout),
        .Cout     (Cout),
        .alu_op   (alu_op)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // At most one bus driver at any time
    always @(negedge Clock) begin
        if (mon_en) begin
            checks++;
            if (!$onehot0(bus)) begin
                errors++;
                $display("FAIL bus_onehot: got bus drivers=%b, required at most one high", bus);
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Clear = 1'b1;
        Stop  = 1'b0;
        IR    = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({Run, alu_op, strobes} !== 28'd0) begin
                errors++;
                $display("FAIL reset cycle %0d: got run=%b alu_op=%b strobes=%h, required all zero",
                         i, Run, alu_op, strobes);
            end
        end
        mon_en = 1'b1;
        Clear  = 1'b0;
        step();
        checks++;
        if ({Run, alu_op, strobes} !== {1'b1, 5'd0, F0}) begin
            errors++;
            $display("FAIL reset_release_t0: got run=%b alu_op=%b strobes=%h, required run=1 alu_op=00000 strobes=%h",
                     Run, alu_op, strobes, F0);
        end
    endtask

    task automatic test_and();
        logic [21:0] es [6];
        logic [4:0]  eo [6];
        es = '{F1, F2, GRB | ROUT | YIN, GRC | ROUT | ZIN, ZLOWOUT | GRA | RIN, F0};
        eo = '{5'd0, 5'd0, 5'd0, 5'b00101, 5'd0, 5'd0};
        IR = 32'h2891_8000;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({Run, alu_op, strobes} !== {1'b1, eo[i], es[i]}) begin
                errors++;
                $display("FAIL and step %0d: got run=%b alu_op=%b strobes=%h, required run=1 alu_op=%b strobes=%h",
                         i + 1, Run, alu_op, strobes, eo[i], es[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [21:0] es [7];
        logic [4:0]  eo [7];
        es = '{F1, F2, GRA | ROUT | YIN, GRB | ROUT | ZIN, ZLOWOUT | LOIN, ZHIGHOUT | HIIN, F0};
        eo = '{5'd0, 5'd0, 5'd0, 5'b10000, 5'd0, 5'd0, 5'd0};
        IR = 32'h8338_0000;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if ({Run, alu_op, strobes} !== {1'b1, eo[i], es[i]}) begin
                errors++;
                $display("FAIL div step %0d: got run=%b alu_op=%b strobes=%h, required run=1 alu_op=%b strobes=%h",
                         i + 1, Run, alu_op, strobes, eo[i], es[i]);
            end
        end
    endtask

    task automatic test_addi();
        logic [21:0] es [6];
        logic [4:0]  eo [6];
        es = '{F1, F2, GRB | ROUT | YIN, COUT | ZIN, ZLOWOUT | GRA | RIN, F0};
        eo = '{5'd0, 5'd0, 5'd0, 5'b01100, 5'd0, 5'd0};
        IR = 32'h6118_0005;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({Run, alu_op, strobes} !== {1'b1, eo[i], es[i]}) begin
                errors++;
                $display("FAIL addi step %0d: got run=%b alu_op=%b strobes=%h, required run=1 alu_op=%b strobes=%h",
                         i + 1, Run, alu_op, strobes, eo[i], es[i]);
            end
        end
    endtask

    task automatic test_unary();
        logic [21:0] es [5];
        logic [4:0]  eo [5];
        es = '{F1, F2, GRB | ROUT | ZIN, ZLOWOUT | GRA | RIN, F0};
        eo = '{5'd0, 5'd0, 5'b10001, 5'd0, 5'd0};
        IR = 32'h8800_0000;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({Run, alu_op, strobes} !== {1'b1, eo[i], es[i]}) begin
                errors++;
                $display("FAIL neg step %0d: got run=%b alu_op=%b strobes=%h, required run=1 alu_op=%b strobes=%h",
                         i + 1, Run, alu_op, strobes, eo[i], es[i]);
            end
        end
    endtask

    // nop and an unlisted opcode both take an idle T3 then refetch
    task automatic test_nop();
        logic [21:0] es [4];
        logic [31:0] irs [2];
        es  = '{F1, F2, 22'd0, F0};
        irs = '{32'hD000_0000, 32'h0000_0000};
        for (int k = 0; k < 2; k++) begin
            IR = irs[k];
            for (int i = 0; i < 4; i++) begin
                step();
                checks++;
                if ({Run, alu_op, strobes} !== {1'b1, 5'd0, es[i]}) begin
                    errors++;
                    $display("FAIL nop ir=%h step %0d: got run=%b alu_op=%b strobes=%h, required run=1 alu_op=00000 strobes=%h",
                             irs[k], i + 1, Run, alu_op, strobes, es[i]);
                end
            end
        end
    endtask

    task automatic test_stop();
        logic [21:0] es [4];
        logic [4:0]  eo [4];
        es = '{F1, F2, GRB | ROUT | YIN, GRC | ROUT | ZIN};
        eo = '{5'd0, 5'd0, 5'd0, 5'b00011};
        IR = 32'h1800_0000;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({Run, alu_op, strobes} !== {1'b1, eo[i], es[i]}) begin
                errors++;
                $display("FAIL stop_add step %0d: got run=%b alu_op=%b strobes=%h, required run=1 alu_op=%b strobes=%h",
                         i + 1, Run, alu_op, strobes, eo[i], es[i]);
            end
        end
        Stop = 1'b1;
        step();
        checks++;
        if ({Run, alu_op, strobes} !== {1'b1, 5'd0, ZLOWOUT | GRA | RIN}) begin
            errors++;
            $display("FAIL stop_completes_t5: got run=%b alu_op=%b strobes=%h, required run=1 strobes=%h",
                     Run, alu_op, strobes, ZLOWOUT | GRA | RIN);
        end
        step();
        Stop = 1'b0;
        checks++;
        if ({Run, alu_op, strobes} !== 28'd0) begin
            errors++;
            $display("FAIL stop_halted: got run=%b alu_op=%b strobes=%h, required all zero",
                     Run, alu_op, strobes);
        end
        step();
        checks++;
        if ({Run, alu_op, strobes} !== 28'd0) begin
            errors++;
            $display("FAIL stop_halted_hold: got run=%b alu_op=%b strobes=%h, required all zero",
                     Run, alu_op, strobes);
        end
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        step();
        checks++;
        if ({Run, alu_op, strobes} !== {1'b1, 5'd0, F0}) begin
            errors++;
            $display("FAIL stop_restart: got run=%b alu_op=%b strobes=%h, required run=1 strobes=%h",
                     Run, alu_op, strobes, F0);
        end
    endtask

    task automatic test_clear_mid_mul();
        logic [21:0] es [4];
        logic [4:0]  eo [4];
        es = '{F1, F2, GRA | ROUT | YIN, GRB | ROUT | ZIN};
        eo = '{5'd0, 5'd0, 5'd0, 5'b01111};
        IR = 32'h7800_0000;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({Run, alu_op, strobes} !== {1'b1, eo[i], es[i]}) begin
                errors++;
                $display("FAIL mul step %0d: got run=%b alu_op=%b strobes=%h, required run=1 alu_op=%b strobes=%h",
                         i + 1, Run, alu_op, strobes, eo[i], es[i]);
            end
        end
        Clear = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({Run, alu_op, strobes} !== 28'd0) begin
                errors++;
                $display("FAIL mul_clear cycle %0d: got run=%b alu_op=%b strobes=%h, required all zero",
                         i, Run, alu_op, strobes);
            end
        end
        Clear = 1'b0;
        step();
        checks++;
        if ({Run, alu_op, strobes} !== {1'b1, 5'd0, F0}) begin
            errors++;
            $display("FAIL mul_clear_restart: got run=%b alu_op=%b strobes=%h, required run=1 strobes=%h",
                     Run, alu_op, strobes, F0);
        end
    endtask

    // Clear at T3 of halt (with Stop also high) must win: RST, then refetch
    task automatic test_clear_over_halt();
        IR = 32'hD800_0000;
        step();
        step();
        step();
        checks++;
        if ({Run, alu_op, strobes} !== {1'b1, 5'd0, 22'd0}) begin
            errors++;
            $display("FAIL clr_halt_t3: got run=%b alu_op=%b strobes=%h, required run=1 no strobes",
                     Run, alu_op, strobes);
        end
        Clear = 1'b1;
        Stop  = 1'b1;
        step();
        Clear = 1'b0;
        Stop  = 1'b0;
        step();
        checks++;
        if ({Run, alu_op, strobes} !== {1'b1, 5'd0, F0}) begin
            errors++;
            $display("FAIL clr_halt_priority: got run=%b alu_op=%b strobes=%h, required run=1 strobes=%h",
                     Run, alu_op, strobes, F0);
        end
    endtask

    task automatic test_halt();
        logic [21:0] es [3];
        es = '{F1, F2, 22'd0};
        IR = 32'hD800_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({Run, alu_op, strobes} !== {1'b1, 5'd0, es[i]}) begin
                errors++;
                $display("FAIL halt step %0d: got run=%b alu_op=%b strobes=%h, required run=1 strobes=%h",
                         i + 1, Run, alu_op, strobes, es[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({Run, alu_op, strobes} !== 28'd0) begin
                errors++;
                $display("FAIL halted cycle %0d: got run=%b alu_op=%b strobes=%h, required all zero",
                         i, Run, alu_op, strobes);
            end
        end
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        step();
        checks++;
        if ({Run, alu_op, strobes} !== {1'b1, 5'd0, F0}) begin
            errors++;
            $display("FAIL halt_restart: got run=%b alu_op=%b strobes=%h, required run=1 strobes=%h",
                     Run, alu_op, strobes, F0);
        end
    endtask

    initial begin
        Clear = 1'b1;
        Stop  = 1'b0;
        IR    = '0;
        test_reset();
        test_and();
        test_div();
        test_addi();
        test_unary();
        test_nop();
        test_stop();
        test_clear_mid_mul();
        test_clear_over_halt();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
